btb_ctrl: RTL and testbench
===========================

BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 Parameter UPD_DEPTH, default 4, SHALL set the depth of the pending-update FIFO (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive denied cycles after which a queued update beats a lookup.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-005 Port lookup_req, input, 1: fetch requests a BTB read this cycle.
REQ-006 Port lookup_pc, input, 32: fetch PC; index = lookup_pc[5:2].
REQ-007 Port lookup_grant, output, 1: read port granted to fetch this cycle.
REQ-008 Port upd_valid, input, 1: execute presents a resolved taken branch.
REQ-009 Port upd_pc, input, 32: branch PC; index = upd_pc[5:2].
REQ-010 Port upd_target, input, 32: ALU-computed jump address.
REQ-011 Port upd_ready, output, 1: FIFO accepts the update this cycle (transfer = upd_valid & upd_ready).
REQ-012 Port flush_req, input, 1: request to invalidate all 16 BTB entries.
REQ-013 Port flush_busy, output, 1: flush sequence in progress.
REQ-014 Port btb_re, output, 1 / btb_rindex, output, 4: BTB read strobe and index.
REQ-015 Port btb_we, output, 1 / btb_windex, output, 4 / btb_wdata, output, 32 / btb_wvalid, output, 1: BTB write strobe, index, target, valid bit.
REQ-016 Port upd_count, output, 4: current FIFO occupancy (0..UPD_DEPTH).

Function
REQ-017 The BTB SHALL be treated as single-ported: at most one of btb_re, btb_we high per cycle.
REQ-018 FSM states SHALL be IDLE and FLUSH; IDLE->FLUSH on flush_req; FLUSH->IDLE after the write to index 15; flush_req in FLUSH ignored.
REQ-019 IDLE arbitration: lookup_req wins unless FIFO full or starve counter = STARVE_LIMIT, in which case FIFO head is written and lookup_grant=0.
REQ-020 lookup_grant, btb_re, btb_rindex SHALL be combinational, same cycle as lookup_req; btb_re=lookup_grant.
REQ-021 Update write: btb_we=1, btb_windex=head pc[5:2], btb_wdata=head target, btb_wvalid=1; head popped at that edge.
REQ-022 With FIFO non-empty and no lookup_req, head SHALL be written that cycle.
REQ-023 Starve counter SHALL increment each IDLE cycle FIFO non-empty and update denied, reset to 0 on any update write or when FIFO empty; saturates at STARVE_LIMIT.
REQ-024 upd_ready SHALL be 1 only in IDLE with FIFO not full; no same-cycle bypass: an update enqueued at edge N is writable earliest in cycle N+1.
REQ-025 Full FIFO with pop this cycle SHALL still show upd_ready=0 (registered full flag).
REQ-026 Same-index updates SHALL both be written in FIFO order (last write wins); no coalescing.
REQ-027 FLUSH: 4-bit counter 0..15, each cycle btb_we=1, btb_windex=counter, btb_wvalid=0, btb_wdata=0; lookup_grant=0, upd_ready=0, flush_busy=1; exactly 16 cycles.
REQ-028 Entry to FLUSH SHALL discard FIFO contents; flush_req and upd_valid in same cycle: flush wins, update not accepted (upd_ready=0 that cycle), starve counter cleared.
REQ-029 upd_count wraps never: pointers wrap modulo UPD_DEPTH, count separate.

Reset
REQ-030 On rst: state IDLE, FIFO empty, upd_count=0, starve and flush counters 0, all outputs 0 except upd_ready=1 in the cycle after reset release.
REQ-031 rst mid-flush SHALL abort the flush and return to IDLE; no further writes issued.

Structure
REQ-032 Package btb_pkg SHALL hold BTB_ENTRIES=16, IDX_W=4, index bit positions [5:2], and the btb_ctrl_state_t enum.
REQ-033 FIFO SHALL be sub-module btb_upd_fifo (push/pop/full/empty/count); arbitration and FSM in btb_ctrl.

Verification
REQ-034 Reset then upd pc=0x0000_0010 tgt=0x0000_0400, no lookups -> next cycle btb_we=1, windex=4, wdata=0x400, wvalid=1.
REQ-035 lookup_req held high, one update queued -> 3 cycles grant, 4th cycle lookup_grant=0 and update written (STARVE_LIMIT=3).
REQ-036 4 updates back-to-back with lookup_req high -> upd_ready=0 after 4th, next cycle update written, upd_count 4->3.
REQ-037 flush_req with 2 queued updates -> 16 cycles windex 0..15 wvalid=0, flush_busy=1, then IDLE, upd_count=0, no stale writes.
REQ-038 flush_req and upd_valid same cycle -> upd_ready=0, update never written.
REQ-039 rst asserted at flush counter=7 -> next cycle btb_we=0, flush_busy=0, state IDLE.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update/lookup controller.
//   BTB_ENTRIES / IDX_W : BTB geometry (16 entries, 4-bit index)
//   IDX_MSB / IDX_LSB   : PC bits that form the BTB index
//   CNT_W               : width of the FIFO occupancy count
//   btb_ctrl_state_t    : controller FSM states
//   upd_entry_t         : one queued BTB update (index + target)
package btb_pkg;

    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned IDX_LSB     = 2;
    localparam int unsigned IDX_MSB     = 5;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } btb_ctrl_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      target;
    } upd_entry_t;

    function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/btb_ctrl_if.sv
// Bus bundle between fetch/execute/BTB array and btb_ctrl.
//   master : requester side (drives lookup, update and flush requests)
//   slave  : btb_ctrl side (drives grants, BTB strobes, status)
interface btb_ctrl_if;
    import btb_pkg::*;

    logic             lookup_req;
    logic [31:0]      lookup_pc;
    logic             lookup_grant;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_ready;
    logic             flush_req;
    logic             flush_busy;
    logic             btb_re;
    logic [IDX_W-1:0] btb_rindex;
    logic             btb_we;
    logic [IDX_W-1:0] btb_windex;
    logic [31:0]      btb_wdata;
    logic             btb_wvalid;
    logic [CNT_W-1:0] upd_count;

    modport master (
        output lookup_req, lookup_pc, upd_valid, upd_pc, upd_target, flush_req,
        input  lookup_grant, upd_ready, flush_busy, btb_re, btb_rindex, btb_we,
               btb_windex, btb_wdata, btb_wvalid, upd_count
    );

    modport slave (
        input  lookup_req, lookup_pc, upd_valid, upd_pc, upd_target, flush_req,
        output lookup_grant, upd_ready, flush_busy, btb_re, btb_rindex, btb_we,
               btb_windex, btb_wdata, btb_wvalid, upd_count
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Pending-update FIFO for BTB writes.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : discard all contents (takes priority over push/pop)
//   push_i       : enqueue push_data_i (ignored when full)
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : oldest entry
//   full_o       : registered full flag
//   empty_o      : no entries
//   count_o      : occupancy, 0..Depth
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  upd_entry_t       push_data_i,
    input  logic             pop_i,
    output upd_entry_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    upd_entry_t       mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q & ~clr_i;
    assign do_pop  = pop_i & (count_q != '0) & ~clr_i;

    // Pointers wrap naturally (Depth is a power of two); occupancy is tracked
    // separately so full and empty never alias.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // Registered so that a pop in a full cycle does not open upd_ready early.
        full_d = (count_d == CNT_W'(Depth));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/btb_ctrl.sv
// BTB port controller: arbitrates the single BTB port between fetch lookups and
// queued branch updates, and sequences a 16-entry invalidating flush.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : lookup request/grant, update valid/ready, flush request/busy,
//              BTB read/write strobes, FIFO occupancy
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned UPD_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic       clk,
    input logic       rst,
    btb_ctrl_if.slave bus_io
);

    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0]   LastIdx   = IDX_W'(BTB_ENTRIES - 1);

    btb_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [StarveW-1:0] starve_q, starve_d;

    logic             fifo_push, fifo_pop, fifo_clr;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    upd_entry_t       fifo_head;
    upd_entry_t       fifo_in;

    logic             force_upd, upd_write;
    logic             grant, ready, busy;
    logic             we, wvalid;
    logic [IDX_W-1:0] windex;
    logic [31:0]      wdata;

    assign fifo_in.idx    = pc_index(bus_io.upd_pc);
    assign fifo_in.target = bus_io.upd_target;

    btb_upd_fifo #(
        .Depth (UPD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (fifo_clr),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        starve_d    = starve_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clr    = 1'b0;
        force_upd   = 1'b0;
        upd_write   = 1'b0;
        grant       = 1'b0;
        ready       = 1'b0;
        busy        = 1'b0;
        we          = 1'b0;
        windex      = '0;
        wdata       = '0;
        wvalid      = 1'b0;
        // Outputs held quiet while reset is asserted so an aborted flush
        // issues no further writes.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    force_upd = !fifo_empty && (fifo_full || starve_q == StarveMax);
                    grant     = bus_io.lookup_req && !force_upd;
                    upd_write = !fifo_empty && !grant;
                    // A flush request in the same cycle refuses the update.
                    ready     = !fifo_full && !bus_io.flush_req;
                    fifo_push = bus_io.upd_valid && ready;
                    fifo_pop  = upd_write;
                    if (upd_write) begin
                        we     = 1'b1;
                        windex = fifo_head.idx;
                        wdata  = fifo_head.target;
                        wvalid = 1'b1;
                    end
                    if (upd_write || fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                    if (bus_io.flush_req) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                        starve_d    = '0;
                        fifo_clr    = 1'b1;
                    end
                end
                StFlush: begin
                    busy        = 1'b1;
                    we          = 1'b1;
                    windex      = flush_cnt_q;
                    flush_cnt_d = flush_cnt_q + IDX_W'(1);
                    if (flush_cnt_q == LastIdx) state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            starve_q    <= starve_d;
        end
    end

    assign bus_io.lookup_grant = grant;
    assign bus_io.btb_re       = grant;
    assign bus_io.btb_rindex   = grant ? pc_index(bus_io.lookup_pc) : '0;
    assign bus_io.upd_ready    = ready;
    assign bus_io.flush_busy   = busy;
    assign bus_io.btb_we       = we;
    assign bus_io.btb_windex   = windex;
    assign bus_io.btb_wdata    = wdata;
    assign bus_io.btb_wvalid   = wvalid;
    assign bus_io.upd_count    = rst ? '0 : fifo_count;

    // Only the index bits of the PCs are meaningful to the BTB.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus_io.lookup_pc[31:IDX_MSB+1], bus_io.lookup_pc[IDX_LSB-1:0],
                              bus_io.upd_pc[31:IDX_MSB+1], bus_io.upd_pc[IDX_LSB-1:0]};

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the port arbiter.
module tb_btb_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] tgt;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    btb_ctrl_if bus ();

    btb_ctrl #(
        .UPD_DEPTH    (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    ent_t        mq[$];
    int          m_starve;
    bit          m_flushing;
    int          m_fidx;
    logic [49:0] exp_vec;
    bit          e_write;
    bit          e_ready;

    function automatic logic [49:0] observe();
        return {bus.lookup_grant, bus.btb_re, bus.btb_rindex, bus.btb_we, bus.btb_windex,
                bus.btb_wdata, bus.btb_wvalid, bus.upd_ready, bus.flush_busy, bus.upd_count};
    endfunction

    task automatic predict();
        logic g, w, wv, rdy, busy, ne, frc;
        logic [3:0] ri, wi, cnt;
        logic [31:0] wd;
        g = 0; w = 0; wv = 0; rdy = 0; busy = 0; ri = 0; wi = 0; cnt = 0; wd = 0;
        if (rst) begin
            // everything quiet
        end else if (m_flushing) begin
            w    = 1;
            wi   = m_fidx[3:0];
            busy = 1;
        end else begin
            ne  = (mq.size() != 0);
            frc = ne && (mq.size() == DEPTH || m_starve == LIMIT);
            g   = bus.lookup_req && !frc;
            if (g) ri = bus.lookup_pc[5:2];
            w = ne && !g;
            if (w) begin
                wi = mq[0].idx;
                wd = mq[0].tgt;
                wv = 1;
            end
            rdy = (mq.size() < DEPTH) && !bus.flush_req;
            cnt = 4'(mq.size());
        end
        e_write = w && !m_flushing;
        e_ready = rdy;
        exp_vec = {g, g, ri, w, wi, wd, wv, rdy, busy, cnt};
    endtask

    task automatic commit();
        bit was_empty;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_starve   = 0;
            m_flushing = 0;
            m_fidx     = 0;
        end else if (m_flushing) begin
            if (m_fidx == 15) m_flushing = 0;
            m_fidx = (m_fidx + 1) % 16;
        end else begin
            was_empty = (mq.size() == 0);
            if (e_write) mq.delete(0);
            if (e_ready && bus.upd_valid) begin
                e.idx = bus.upd_pc[5:2];
                e.tgt = bus.upd_target;
                mq.push_back(e);
            end
            if (e_write || was_empty) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (bus.flush_req) begin
                m_flushing = 1;
                m_fidx     = 0;
                mq.delete();
                m_starve   = 0;
            end
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        predict();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic drive(input logic lreq, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic [31:0] utgt, input logic freq);
        bus.lookup_req = lreq;
        bus.lookup_pc  = lpc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_target = utgt;
        bus.flush_req  = freq;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) begin
            cyc_begin();
            checks++;
            if (observe() !== 50'd0) begin
                failures++;
                $display("FAIL reset_hold: got %h want 0", observe());
            end
            cyc_end();
        end
        rst = 1'b0;
        cyc_begin();
        checks++;
        if (observe() !== {46'd0, 1'b1, 1'b0, 4'd0} || observe() !== exp_vec) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
    endtask

    task automatic test_single_update();
        drive(0, 0, 1, 32'h0000_0010, 32'h0000_0400, 0);
        cyc_begin();
        checks++;
        if (observe() !== exp_vec || bus.upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_enq: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        drive(0, 0, 0, 0, 0, 0);
        cyc_begin();
        checks++;
        if ({bus.btb_we, bus.btb_windex, bus.btb_wdata, bus.btb_wvalid} !==
            {1'b1, 4'd4, 32'h0000_0400, 1'b1} || observe() !== exp_vec) begin
            failures++;
            $display("FAIL single_write: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
    endtask

    task automatic test_starvation();
        drive(1, $urandom, 1, $urandom, $urandom, 0);
        cyc_begin();
        checks++;
        if (observe() !== exp_vec) begin
            failures++;
            $display("FAIL starve_enq: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom, 0, 0, 0, 0);
            cyc_begin();
            checks++;
            if (bus.lookup_grant !== (i < 3) || bus.btb_we !== (i == 3) ||
                observe() !== exp_vec) begin
                failures++;
                $display("FAIL starve_cycle%0d: got %h want %h", i, observe(), exp_vec);
            end
            cyc_end();
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom, 1, $urandom, $urandom, 0);
            cyc_begin();
            checks++;
            if (bus.upd_ready !== 1'b1 || observe() !== exp_vec) begin
                failures++;
                $display("FAIL full_fill%0d: got %h want %h", i, observe(), exp_vec);
            end
            cyc_end();
        end
        drive(1, $urandom, 1, $urandom, $urandom, 0);
        cyc_begin();
        checks++;
        if (bus.upd_ready !== 1'b0 || bus.btb_we !== 1'b1 || bus.upd_count !== 4'd4 ||
            bus.lookup_grant !== 1'b0 || observe() !== exp_vec) begin
            failures++;
            $display("FAIL full_refuse: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        cyc_begin();
        checks++;
        if (bus.upd_count !== 4'd3 || observe() !== exp_vec) begin
            failures++;
            $display("FAIL full_pop: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) begin
            cyc_begin();
            checks++;
            if (observe() !== exp_vec) begin
                failures++;
                $display("FAIL full_drain: got %h want %h", observe(), exp_vec);
            end
            cyc_end();
        end
    endtask

    task automatic test_same_index();
        drive(0, 0, 1, 32'h0000_0024, 32'hAAAA_0000, 0);
        cyc_begin();
        cyc_end();
        drive(0, 0, 1, 32'h0000_0064, 32'hBBBB_0000, 0);
        cyc_begin();
        checks++;
        if ({bus.btb_we, bus.btb_windex, bus.btb_wdata} !== {1'b1, 4'd9, 32'hAAAA_0000} ||
            observe() !== exp_vec) begin
            failures++;
            $display("FAIL same_idx_first: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        drive(0, 0, 0, 0, 0, 0);
        cyc_begin();
        checks++;
        if ({bus.btb_we, bus.btb_windex, bus.btb_wdata} !== {1'b1, 4'd9, 32'hBBBB_0000} ||
            observe() !== exp_vec) begin
            failures++;
            $display("FAIL same_idx_second: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom, 1, $urandom, $urandom, 0);
            cyc_begin();
            cyc_end();
        end
        drive(1, $urandom, 0, 0, 0, 1);
        cyc_begin();
        checks++;
        if (bus.upd_count !== 4'd2 || observe() !== exp_vec) begin
            failures++;
            $display("FAIL flush_entry: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        for (int i = 0; i < 16; i++) begin
            drive(1, $urandom, 1, $urandom, $urandom, (i == 5));
            cyc_begin();
            checks++;
            if ({bus.btb_we, bus.btb_windex, bus.btb_wvalid, bus.btb_wdata, bus.flush_busy,
                 bus.lookup_grant, bus.upd_ready} !==
                {1'b1, 4'(i), 1'b0, 32'd0, 1'b1, 1'b0, 1'b0} || observe() !== exp_vec) begin
                failures++;
                $display("FAIL flush_step%0d: got %h want %h", i, observe(), exp_vec);
            end
            cyc_end();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            cyc_begin();
            checks++;
            if (bus.btb_we !== 1'b0 || bus.upd_count !== 4'd0 || bus.flush_busy !== 1'b0 ||
                observe() !== exp_vec) begin
                failures++;
                $display("FAIL flush_after: got %h want %h", observe(), exp_vec);
            end
            cyc_end();
        end
    endtask

    task automatic test_flush_with_update();
        drive(0, 0, 1, 32'h0000_0030, 32'h1234_5678, 1);
        cyc_begin();
        checks++;
        if (bus.upd_ready !== 1'b0 || observe() !== exp_vec) begin
            failures++;
            $display("FAIL flush_upd_ready: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
        drive(0, 0, 0, 0, 0, 0);
        repeat (19) begin
            cyc_begin();
            checks++;
            if ((bus.btb_we && bus.btb_wvalid) !== 1'b0 || observe() !== exp_vec) begin
                failures++;
                $display("FAIL flush_upd_dropped: got %h want %h", observe(), exp_vec);
            end
            cyc_end();
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(0, 0, 0, 0, 0, 1);
        cyc_begin();
        cyc_end();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc_begin();
            checks++;
            if (bus.btb_windex !== 4'(i) || observe() !== exp_vec) begin
                failures++;
                $display("FAIL midflush_step%0d: got %h want %h", i, observe(), exp_vec);
            end
            cyc_end();
        end
        rst = 1'b1;
        cyc_begin();
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        checks++;
        if ({bus.btb_we, bus.flush_busy, bus.upd_ready} !== 3'b001 ||
            observe() !== exp_vec) begin
            failures++;
            $display("FAIL midflush_reset: got %h want %h", observe(), exp_vec);
        end
        cyc_end();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 1), $urandom,
                  $urandom, ($urandom_range(0, 63) == 0));
            cyc_begin();
            checks++;
            if (observe() !== exp_vec || (bus.btb_re && bus.btb_we)) begin
                failures++;
                $display("FAIL random_cyc%0d: got %h want %h", n, observe(), exp_vec);
            end
            cyc_end();
        end
        rst = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        m_starve   = 0;
        m_flushing = 0;
        m_fidx     = 0;
        rst        = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_update();
        test_starvation();
        test_fifo_full();
        test_same_index();
        test_flush();
        test_flush_with_update();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
